// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built in when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        inv,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = {lookup_pc[31], lookup_pc[IDX_W+2 +: TAG_W-1]};
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  // Fall-through keeps bit 31 (supervisor bit) untouched by the +4.
  assign pred_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
  assign pred_target = pred_taken ? r_target[w_lk_idx]
                                  : {lookup_pc[31], lookup_pc[30:0] + 31'd4};

  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = {upd_pc[31], upd_pc[IDX_W+2 +: TAG_W-1]};
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = r_ctr[w_up_idx];

  assign mispredict  = upd_valid &
                       ((upd_taken != upd_pred_taken) |
                        (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : {upd_pc[31], upd_pc[30:0] + 31'd4};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WN;
      end
    end else if (inv) begin
      // Counters and targets go stale; they are unreachable until reallocated.
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          r_ctr[w_up_idx]    <= (w_up_ctr == CTR_ST) ? CTR_ST : w_up_ctr + 2'd1;
          r_target[w_up_idx] <= upd_target;
        end else begin
          r_ctr[w_up_idx] <= (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Counting ignores inv so that flushes do not hide branches from the totals.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid) begin
      if (r_stat_br != 32'hFFFF_FFFF) r_stat_br <= r_stat_br + 32'd1;
      if (mispredict && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
